// File: rtl/t03_branch_predict_unit_pkg.sv
// t03_branch_pkg: shared definitions for the branch predict unit.
//   - condition-code constants for conditional branches
//   - jump-kind constants
//   - BTB entry struct; tag/target/ctr fields are sized for the widest
//     configuration and each instance uses only the low bits it needs,
//     so one package type serves every parameterisation
package t03_branch_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;

    // Widest supported XLEN and counter width for a stored entry.
    localparam int BTB_MAX_XLEN = 64;
    localparam int BTB_MAX_CTR  = 8;

    typedef struct packed {
        logic                    valid;
        logic                    is_jump;
        logic [BTB_MAX_XLEN-1:0] tag;
        logic [BTB_MAX_XLEN-1:0] target;
        logic [BTB_MAX_CTR-1:0]  ctr;
    } btb_entry_t;

endpackage

// File: rtl/t03_branch_predict_unit_if.sv
// t03_branch_predict_unit_if: fetch lookup, execute resolve and redirect
// signals of the branch predict unit.
//   master: pipeline side (drives f_pc and ex_*, receives predictions/redirect)
//   slave : predict unit side
interface t03_branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  f_pc;
    logic             f_pred_taken;
    logic [XLEN-1:0]  f_pred_target;
    logic             ex_valid;
    logic             ex_stall;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_target;
    logic [2:0]       ex_branch;
    logic             ex_is_branch;
    logic [1:0]       ex_jump;
    logic             ex_zero;
    logic             ex_negative;
    logic             ex_overflow;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output f_pc, ex_valid, ex_stall, ex_pc, ex_target, ex_branch,
               ex_is_branch, ex_jump, ex_zero, ex_negative, ex_overflow,
               ex_pred_taken, ex_pred_target,
        input  f_pred_taken, f_pred_target, redirect, redirect_pc,
               mispredict_count
    );

    modport slave (
        input  f_pc, ex_valid, ex_stall, ex_pc, ex_target, ex_branch,
               ex_is_branch, ex_jump, ex_zero, ex_negative, ex_overflow,
               ex_pred_taken, ex_pred_target,
        output f_pred_taken, f_pred_target, redirect, redirect_pc,
               mispredict_count
    );
endinterface

// File: rtl/t03_branch_predict_unit_cond.sv
// t03_branch_cond: combinational branch/jump condition evaluator.
//   branch   : condition code
//   jump     : jump kind (JAL/JALR always taken)
//   zero/negative/overflow : ALU flags
//   actual_taken : resolved direction
module t03_branch_cond
    import t03_branch_pkg::*;
(
    input  logic [2:0] branch,
    input  logic [1:0] jump,
    input  logic       zero,
    input  logic       negative,
    input  logic       overflow,
    output logic       actual_taken
);

    // Decode direction; codes 010/011 are reserved and resolve not taken.
    always_comb begin
        actual_taken = 1'b0;
        if ((jump == J_JAL) || (jump == J_JALR)) begin
            actual_taken = 1'b1;
        end else begin
            case (branch)
                BR_EQ:   actual_taken = zero;
                BR_NE:   actual_taken = ~zero;
                BR_LT:   actual_taken = negative;
                BR_GE:   actual_taken = ~negative;
                BR_LTU:  actual_taken = overflow;
                BR_GEU:  actual_taken = ~overflow;
                default: actual_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/t03_branch_predict_unit.sv
// t03_branch_predict_unit: direct-mapped BTB with saturating direction
// counters plus execute-stage branch resolution.
//   clk, rst : clock, asynchronous active-high reset
//   bif      : slave side of t03_branch_predict_unit_if
//              fetch lookup (f_pc -> f_pred_taken/f_pred_target),
//              execute resolve (ex_*), registered redirect/redirect_pc,
//              saturating mispredict_count
module t03_branch_predict_unit
    import t03_branch_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    t03_branch_predict_unit_if.slave  bif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;   // MSB 0, rest 1
    localparam logic [CTR_BITS-1:0] CTR_WT  = ~CTR_WNT;       // MSB 1, rest 0
    localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

    btb_entry_t        btb_q [ENTRIES];
    btb_entry_t        btb_d [ENTRIES];
    logic              redirect_q, redirect_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [IDX_W-1:0]  f_idx_s, ex_idx_s;
    logic [TAG_W-1:0]  f_tag_s, ex_tag_s;
    btb_entry_t        f_ent_s, ex_ent_s;
    logic              f_hit_s, f_taken_s, ex_hit_s;
    logic [XLEN-1:0]   f_target_s, next_pc_s;
    logic              actual_taken_s, ex_is_jump_s, fire_s, mispredict_s;
    logic [CTR_BITS-1:0] cur_ctr_s, new_ctr_s;
    logic              unused_pc_bits_s;

    // Byte-offset PC bits never participate in index or tag.
    assign unused_pc_bits_s = ^{bif.f_pc[1:0], bif.ex_pc[1:0]};

    t03_branch_cond u_cond (
        .branch       (bif.ex_branch),
        .jump         (bif.ex_jump),
        .zero         (bif.ex_zero),
        .negative     (bif.ex_negative),
        .overflow     (bif.ex_overflow),
        .actual_taken (actual_taken_s)
    );

    // Fetch lookup from registered table state (no bypass from resolve).
    always_comb begin
        f_idx_s   = bif.f_pc[2 +: IDX_W];
        f_tag_s   = bif.f_pc[XLEN-1 -: TAG_W];
        f_ent_s   = btb_q[f_idx_s];
        f_hit_s   = f_ent_s.valid && (f_ent_s.tag == BTB_MAX_XLEN'(f_tag_s));
        f_taken_s = f_hit_s && (f_ent_s.is_jump || f_ent_s.ctr[CTR_BITS-1]);
        if (f_taken_s) begin
            f_target_s = XLEN'(f_ent_s.target);
        end else begin
            f_target_s = bif.f_pc + XLEN'(32'd4);
        end
    end

    // Resolve: fire condition, correct next PC and mispredict detection.
    always_comb begin
        ex_idx_s     = bif.ex_pc[2 +: IDX_W];
        ex_tag_s     = bif.ex_pc[XLEN-1 -: TAG_W];
        ex_is_jump_s = (bif.ex_jump == J_JAL) || (bif.ex_jump == J_JALR);
        fire_s       = bif.ex_valid && !bif.ex_stall &&
                       (bif.ex_is_branch || (bif.ex_jump != J_NONE));
        if (actual_taken_s) begin
            next_pc_s = bif.ex_target;
        end else begin
            next_pc_s = bif.ex_pc + XLEN'(32'd4);
        end
        mispredict_s = (actual_taken_s != bif.ex_pred_taken) ||
                       (actual_taken_s && (bif.ex_target != bif.ex_pred_target));
    end

    // Next state: redirect pulse, statistics counter and BTB update.
    always_comb begin
        btb_d         = btb_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        count_d       = count_q;
        ex_ent_s      = btb_q[ex_idx_s];
        ex_hit_s      = ex_ent_s.valid && (ex_ent_s.tag == BTB_MAX_XLEN'(ex_tag_s));
        cur_ctr_s     = CTR_BITS'(ex_ent_s.ctr);
        new_ctr_s     = cur_ctr_s;
        if (fire_s) begin
            if (mispredict_s) begin
                redirect_d    = 1'b1;
                redirect_pc_d = next_pc_s;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1'b1);
                end else begin
                    count_d = count_q;
                end
            end else begin
                redirect_d = 1'b0;
            end
            if (ex_hit_s) begin
                if (actual_taken_s) begin
                    new_ctr_s = (cur_ctr_s == CTR_MAX) ? cur_ctr_s : cur_ctr_s + CTR_BITS'(1'b1);
                    btb_d[ex_idx_s].target = BTB_MAX_XLEN'(bif.ex_target);
                end else begin
                    new_ctr_s = (cur_ctr_s == '0) ? cur_ctr_s : cur_ctr_s - CTR_BITS'(1'b1);
                end
                btb_d[ex_idx_s].ctr = BTB_MAX_CTR'(new_ctr_s);
            end else if (actual_taken_s) begin
                // Allocate (overwriting any aliasing entry); jumps start saturated.
                btb_d[ex_idx_s] = '{valid:   1'b1,
                                    is_jump: ex_is_jump_s,
                                    tag:     BTB_MAX_XLEN'(ex_tag_s),
                                    target:  BTB_MAX_XLEN'(bif.ex_target),
                                    ctr:     BTB_MAX_CTR'(ex_is_jump_s ? CTR_MAX : CTR_WT)};
            end else begin
                btb_d[ex_idx_s] = ex_ent_s;
            end
        end else begin
            redirect_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, is_jump: 1'b0, tag: '0, target: '0,
                              ctr: BTB_MAX_CTR'(CTR_WNT)};
            end
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            count_q       <= '0;
        end else begin
            btb_q         <= btb_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            count_q       <= count_d;
        end
    end

    assign bif.f_pred_taken     = f_taken_s;
    assign bif.f_pred_target    = f_target_s;
    assign bif.redirect         = redirect_q;
    assign bif.redirect_pc      = redirect_pc_q;
    assign bif.mispredict_count = count_q;

endmodule

// File: tb/tb_t03_branch_predict_unit.sv
module tb_t03_branch_predict_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    t03_branch_predict_unit_if #(.XLEN(32), .CNT_W(16)) bif ();

    t03_branch_predict_unit #(
        .XLEN(32), .ENTRIES(16), .CTR_BITS(2), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    always #5 clk = ~clk;

    // Present one execute-stage instruction for a single clock edge.
    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [2:0] br, input logic isb, input logic [1:0] jmp,
                           input logic z, input logic n, input logic o,
                           input logic pt, input logic [31:0] ptg, input logic stall);
        bif.ex_valid = 1'b1;      bif.ex_stall = stall;
        bif.ex_pc = pc;           bif.ex_target = tgt;
        bif.ex_branch = br;       bif.ex_is_branch = isb;
        bif.ex_jump = jmp;        bif.ex_zero = z;
        bif.ex_negative = n;      bif.ex_overflow = o;
        bif.ex_pred_taken = pt;   bif.ex_pred_target = ptg;
        @(posedge clk); #1;
        bif.ex_valid = 1'b0;      bif.ex_stall = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic set_fpc(input logic [31:0] pc);
        bif.f_pc = pc; #1;
    endtask

    task automatic test_reset();
        set_fpc(32'h100);
        checks++; if (bif.f_pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred_taken got=%0h exp=0", bif.f_pred_taken); end
        checks++; if (bif.f_pred_target !== 32'h104) begin failures++; $display("FAIL rst_pred_target got=%0h exp=104", bif.f_pred_target); end
        checks++; if (bif.mispredict_count !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bif.mispredict_count); end
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%0h exp=0", bif.redirect); end
        checks++; if (bif.redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect_pc got=%0h exp=0", bif.redirect_pc); end
    endtask

    task automatic test_branch_train();
        resolve(32'h100, 32'h80, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (bif.redirect !== 1'b1) begin failures++; $display("FAIL beq_redirect got=%0h exp=1", bif.redirect); end
        checks++; if (bif.redirect_pc !== 32'h80) begin failures++; $display("FAIL beq_redirect_pc got=%0h exp=80", bif.redirect_pc); end
        checks++; if (bif.mispredict_count !== 16'd1) begin failures++; $display("FAIL beq_count got=%0d exp=1", bif.mispredict_count); end
        idle_cycle();
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL beq_pulse_end got=%0h exp=0", bif.redirect); end
        set_fpc(32'h100);
        checks++; if (bif.f_pred_taken !== 1'b1) begin failures++; $display("FAIL beq_pred_taken got=%0h exp=1", bif.f_pred_taken); end
        checks++; if (bif.f_pred_target !== 32'h80) begin failures++; $display("FAIL beq_pred_target got=%0h exp=80", bif.f_pred_target); end
        for (int k = 0; k < 2; k++) begin
            resolve(32'h100, 32'h80, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
            checks++; if (bif.redirect !== 1'b1 || bif.redirect_pc !== 32'h104) begin failures++; $display("FAIL nt_redirect[%0d] got=%0h/%0h exp=1/104", k, bif.redirect, bif.redirect_pc); end
        end
        checks++; if (bif.mispredict_count !== 16'd3) begin failures++; $display("FAIL nt_count got=%0d exp=3", bif.mispredict_count); end
        checks++; if (bif.f_pred_taken !== 1'b0 || bif.f_pred_target !== 32'h104) begin failures++; $display("FAIL nt_pred got=%0h/%0h exp=0/104", bif.f_pred_taken, bif.f_pred_target); end
    endtask

    task automatic test_jalr();
        resolve(32'h200, 32'h300, 3'b000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (bif.redirect !== 1'b1 || bif.redirect_pc !== 32'h300) begin failures++; $display("FAIL jalr1_redirect got=%0h/%0h exp=1/300", bif.redirect, bif.redirect_pc); end
        checks++; if (bif.mispredict_count !== 16'd4) begin failures++; $display("FAIL jalr1_count got=%0d exp=4", bif.mispredict_count); end
        set_fpc(32'h200);
        checks++; if (bif.f_pred_taken !== 1'b1 || bif.f_pred_target !== 32'h300) begin failures++; $display("FAIL jalr1_pred got=%0h/%0h exp=1/300", bif.f_pred_taken, bif.f_pred_target); end
        set_fpc(32'h240);
        checks++; if (bif.f_pred_taken !== 1'b0 || bif.f_pred_target !== 32'h244) begin failures++; $display("FAIL alias_tag_miss got=%0h/%0h exp=0/244", bif.f_pred_taken, bif.f_pred_target); end
        resolve(32'h200, 32'h340, 3'b000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        checks++; if (bif.redirect !== 1'b1 || bif.redirect_pc !== 32'h340) begin failures++; $display("FAIL jalr2_redirect got=%0h/%0h exp=1/340", bif.redirect, bif.redirect_pc); end
        checks++; if (bif.mispredict_count !== 16'd5) begin failures++; $display("FAIL jalr2_count got=%0d exp=5", bif.mispredict_count); end
        set_fpc(32'h200);
        checks++; if (bif.f_pred_taken !== 1'b1 || bif.f_pred_target !== 32'h340) begin failures++; $display("FAIL jalr2_pred got=%0h/%0h exp=1/340", bif.f_pred_taken, bif.f_pred_target); end
    endtask

    task automatic test_stall();
        resolve(32'h400, 32'h500, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL stall_redirect got=%0h exp=0", bif.redirect); end
        checks++; if (bif.mispredict_count !== 16'd5) begin failures++; $display("FAIL stall_count got=%0d exp=5", bif.mispredict_count); end
        set_fpc(32'h200);
        checks++; if (bif.f_pred_taken !== 1'b1 || bif.f_pred_target !== 32'h340) begin failures++; $display("FAIL stall_table_kept got=%0h/%0h exp=1/340", bif.f_pred_taken, bif.f_pred_target); end
        resolve(32'h400, 32'h500, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (bif.redirect !== 1'b1 || bif.redirect_pc !== 32'h500) begin failures++; $display("FAIL unstall_redirect got=%0h/%0h exp=1/500", bif.redirect, bif.redirect_pc); end
        checks++; if (bif.mispredict_count !== 16'd6) begin failures++; $display("FAIL unstall_count got=%0d exp=6", bif.mispredict_count); end
        set_fpc(32'h400);
        checks++; if (bif.f_pred_taken !== 1'b1 || bif.f_pred_target !== 32'h500) begin failures++; $display("FAIL unstall_pred got=%0h/%0h exp=1/500", bif.f_pred_taken, bif.f_pred_target); end
    endtask

    task automatic test_cond_codes();
        // Reserved code 010 is not taken even with zero set: correct prediction.
        resolve(32'h800, 32'h900, 3'b010, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL code010_redirect got=%0h exp=0", bif.redirect); end
        // Overflow-taken, correctly predicted: no redirect, allocates weakly taken.
        resolve(32'h800, 32'h900, 3'b110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h900, 1'b0);
        checks++; if (bif.redirect !== 1'b0 || bif.mispredict_count !== 16'd6) begin failures++; $display("FAIL code110_ok got=%0h/%0d exp=0/6", bif.redirect, bif.mispredict_count); end
        set_fpc(32'h800);
        checks++; if (bif.f_pred_taken !== 1'b1 || bif.f_pred_target !== 32'h900) begin failures++; $display("FAIL code110_alloc got=%0h/%0h exp=1/900", bif.f_pred_taken, bif.f_pred_target); end
        // ~overflow with overflow set: not taken, ctr 10 -> 01.
        resolve(32'h800, 32'h900, 3'b111, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL code111_redirect got=%0h exp=0", bif.redirect); end
        checks++; if (bif.f_pred_taken !== 1'b0 || bif.f_pred_target !== 32'h804) begin failures++; $display("FAIL code111_ctr got=%0h/%0h exp=0/804", bif.f_pred_taken, bif.f_pred_target); end
        // ~negative with negative clear: taken, ctr 01 -> 10.
        resolve(32'h800, 32'h900, 3'b101, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h900, 1'b0);
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL code101_redirect got=%0h exp=0", bif.redirect); end
        checks++; if (bif.f_pred_taken !== 1'b1 || bif.f_pred_target !== 32'h900) begin failures++; $display("FAIL code101_ctr got=%0h/%0h exp=1/900", bif.f_pred_taken, bif.f_pred_target); end
    endtask

    task automatic test_back_to_back();
        // BNE not taken at the top of the address space: next PC wraps to 0.
        resolve(32'hFFFF_FFFC, 32'h10, 3'b001, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        checks++; if (bif.redirect !== 1'b1 || bif.redirect_pc !== 32'h0) begin failures++; $display("FAIL b2b1_redirect got=%0h/%0h exp=1/0", bif.redirect, bif.redirect_pc); end
        resolve(32'h600, 32'h700, 3'b100, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (bif.redirect !== 1'b1 || bif.redirect_pc !== 32'h700) begin failures++; $display("FAIL b2b2_redirect got=%0h/%0h exp=1/700", bif.redirect, bif.redirect_pc); end
        checks++; if (bif.mispredict_count !== 16'd8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", bif.mispredict_count); end
        idle_cycle();
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL b2b_pulse_end got=%0h exp=0", bif.redirect); end
        set_fpc(32'hFFFF_FFFC);
        checks++; if (bif.f_pred_taken !== 1'b0 || bif.f_pred_target !== 32'h0) begin failures++; $display("FAIL wrap_no_alloc got=%0h/%0h exp=0/0", bif.f_pred_taken, bif.f_pred_target); end
    endtask

    task automatic test_reset_mid_pulse();
        resolve(32'h100, 32'h80, 3'b000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (bif.redirect !== 1'b1 || bif.mispredict_count !== 16'd9) begin failures++; $display("FAIL pre_rst got=%0h/%0d exp=1/9", bif.redirect, bif.mispredict_count); end
        rst = 1'b1; #1;
        checks++; if (bif.redirect !== 1'b0) begin failures++; $display("FAIL async_rst_redirect got=%0h exp=0", bif.redirect); end
        checks++; if (bif.mispredict_count !== 16'd0 || bif.redirect_pc !== 32'h0) begin failures++; $display("FAIL async_rst_state got=%0d/%0h exp=0/0", bif.mispredict_count, bif.redirect_pc); end
        set_fpc(32'h100);
        checks++; if (bif.f_pred_taken !== 1'b0 || bif.f_pred_target !== 32'h104) begin failures++; $display("FAIL async_rst_lookup got=%0h/%0h exp=0/104", bif.f_pred_taken, bif.f_pred_target); end
        @(negedge clk); rst = 1'b0;
        idle_cycle();
        set_fpc(32'h600);
        checks++; if (bif.f_pred_taken !== 1'b0 || bif.redirect !== 1'b0) begin failures++; $display("FAIL post_rst got=%0h/%0h exp=0/0", bif.f_pred_taken, bif.redirect); end
    endtask

    initial begin
        bif.f_pc = 32'h0;          bif.ex_valid = 1'b0;      bif.ex_stall = 1'b0;
        bif.ex_pc = 32'h0;         bif.ex_target = 32'h0;    bif.ex_branch = 3'b000;
        bif.ex_is_branch = 1'b0;   bif.ex_jump = 2'b00;      bif.ex_zero = 1'b0;
        bif.ex_negative = 1'b0;    bif.ex_overflow = 1'b0;   bif.ex_pred_taken = 1'b0;
        bif.ex_pred_target = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_branch_train();
        test_jalr();
        test_stall();
        test_cond_codes();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t03_branch_predict_unit.md
Name: t03_branch_predict_unit

Overview:
Parametrised successor to the single-cycle branch-condition decoder. It still resolves branch/jump conditions from ALU flags in the execute stage. It adds a direct-mapped branch target buffer (BTB) with saturating direction counters, so fetch receives a next-PC prediction. It also generates a registered redirect/flush when a resolved branch disagrees with its prediction. It sits between fetch (lookup port) and execute (resolve port).

Parameters:
XLEN, 32, address/target width
ENTRIES, 16, BTB entries; power of two, >= 2
CTR_BITS, 2, direction counter width; >= 1
CNT_W, 16, mispredict statistics counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
f_pc  in  XLEN  fetch PC for lookup
f_pred_taken  out  1  predicted taken (combinational from table state)
f_pred_target  out  XLEN  predicted target; equals f_pc+4 when not predicted taken
ex_valid  in  1  execute stage holds a valid instruction
ex_stall  in  1  execute held; no resolve, no update this cycle
ex_pc  in  XLEN  PC of the execute instruction
ex_target  in  XLEN  computed taken target (branch/JAL/JALR)
ex_branch  in  3  condition code
ex_is_branch  in  1  instruction is a conditional branch
ex_jump  in  2  01 = JAL, 10 = JALR, else none
ex_zero, ex_negative, ex_overflow  in  1 each  ALU flags
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
ex_pred_target  in  XLEN  prediction carried down the pipe with this instruction
redirect  out  1  registered one-cycle pulse: flush younger stages
redirect_pc  out  XLEN  correct next PC; valid while redirect=1
mispredict_count  out  CNT_W  saturating count of redirects

Behaviour:
- Index = pc[2 +: log2(ENTRIES)]; tag = remaining upper bits above the index. Entry = {valid, tag, target, ctr}.
- Lookup: hit = valid && tag match. f_pred_taken = hit && (is_jump bit || ctr MSB). Table reads return pre-update state; there is no same-cycle bypass from the resolve port.
- Resolve fires when ex_valid && !ex_stall && (ex_is_branch || ex_jump != 00).
- Actual direction:
  - jump 01 or 10: taken.
  - Branch codes: 000 zero; 001 ~zero; 100 negative; 101 ~negative; 110 overflow; 111 ~overflow; 010 and 011 not taken.
- Actual next PC = taken ? ex_target : ex_pc+4, with XLEN wrap.
- Mispredict = actual_taken != ex_pred_taken, or (actual_taken && ex_target != ex_pred_target).
- On a mispredict, the next edge sets redirect=1 and redirect_pc = actual next PC for exactly one cycle. Back-to-back mispredicts give back-to-back pulses. mispredict_count increments and saturates at all-ones.
- BTB update on resolve:
  - Tag hit: ctr increments if taken (saturating at max), decrements if not taken (saturating at 0). Target is written when taken.
  - Miss and taken: allocate/overwrite the entry. ctr = weakly taken (MSB=1, rest 0). Jumps set ctr to max and the entry's is_jump bit to 1.
  - Miss and not taken: no allocation.
- JALR entries are stored like JAL entries; a target mismatch counts as a mispredict.
- ex_stall=1 suppresses resolve, update and redirect. A pending redirect already registered still pulses.
- Reset (asynchronous, any time): all valid bits 0, ctrs weakly not-taken (MSB=0, rest 1), redirect=0, redirect_pc=0, mispredict_count=0. f_pred_taken=0 and f_pred_target=f_pc+4 immediately after reset.

Decomposition:
- Shared package t03_branch_pkg holds:
  - condition-code constants BR_EQ=000, BR_NE=001, BR_LT=100, BR_GE=101, BR_LTU=110, BR_GEU=111;
  - jump constants J_NONE=00, J_JAL=01, J_JALR=10;
  - the BTB entry struct typedef.
- One natural sub-module is t03_branch_cond: a combinational condition evaluator taking branch, jump and flags and returning actual_taken. It is instantiated once.

Test Plan:
- Reset, then f_pc=0x100 -> f_pred_taken=0, f_pred_target=0x104; mispredict_count=0.
- Resolve BEQ at ex_pc=0x100, zero=1, ex_target=0x80, ex_pred_taken=0 -> next cycle redirect=1, redirect_pc=0x80, count=1. Following cycle redirect=0, and f_pc=0x100 predicts taken to 0x80.
- Same branch resolved not taken twice (zero=0), each time predicted taken -> two redirects to 0x104, count=3. The entry ctr ends at 0, so f_pred_taken=0.
- JALR at 0x200, target 0x300, then again with target 0x340 while pred_target=0x300 -> second resolve redirects to 0x340 and the BTB target updates to 0x340.
- ex_stall=1 with a mispredicting branch -> no redirect, no count change, no table change. Deasserting the stall resolves it normally.
- Assert rst mid-pulse (redirect=1) -> redirect drops asynchronously, all lookups miss, count=0.
